// File: rtl/cpu_grp1_exec.sv
// rtl/cpu_grp1_exec.sv - 6502 group-1 execute unit (ORA/AND/EOR/ADC/STA/LDA/CMP/SBC)
//
// Owns accumulator A (WIDTH = 8 or 16) and status register P (NV1BDIZC).
// Operands are moved over a byte-wide memory bus with a ready handshake.
//
// Ports:
//   clock, reset_n          clock (rising edge), asynchronous active-low reset
//   start, opcode, ea       instruction request, sampled only in IDLE
//   p_load, p_in            load P (bit 5 forced to 1) when idle and not starting
//   address, read, wren     memory cycle control; held stable until ready
//   i_data, o_data, ready   memory read data, write data, access complete
//   a_out, p_out            architectural A and P
//   busy, done, err         not idle / completion pulse / illegal-opcode pulse
module cpu_grp1_exec #(
  parameter int WIDTH   = 8,
  parameter int DECIMAL = 1
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic [7:0]       opcode,
  input  logic [15:0]      ea,
  input  logic             p_load,
  input  logic [7:0]       p_in,
  output logic [15:0]      address,
  input  logic [7:0]       i_data,
  output logic [7:0]       o_data,
  output logic             read,
  output logic             wren,
  input  logic             ready,
  output logic [WIDTH-1:0] a_out,
  output logic [7:0]       p_out,
  output logic             busy,
  output logic             done,
  output logic             err
);

  typedef enum logic [2:0] {
    S_IDLE, S_RD_LO, S_RD_HI, S_EXEC, S_DEC, S_WR_LO, S_WR_HI
  } state_t;

  localparam logic [2:0] OP_ORA = 3'd0, OP_AND = 3'd1, OP_EOR = 3'd2, OP_ADC = 3'd3,
                         OP_STA = 3'd4, OP_LDA = 3'd5, OP_CMP = 3'd6, OP_SBC = 3'd7;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, m_q, m_d;
  logic [7:0]       p_q, p_d, o_data_q, o_data_d;
  logic [2:0]       op_q, op_d;
  logic [15:0]      ea_q, ea_d;
  logic             done_q, done_d, err_q, err_d;

  // Addressing-mode bits are resolved upstream; only the group and operation matter here.
  logic unused_opcode_bits;
  assign unused_opcode_bits = ^opcode[4:2];

  // Binary ALU: ADC adds M, SBC/CMP add ~M; CMP always injects carry 1.
  logic [WIDTH-1:0] b_opnd, alu_res;
  logic [WIDTH:0]   sum;
  logic             carry_in, v_bin;

  always_comb begin
    b_opnd   = (op_q == OP_ADC) ? m_q : ~m_q;
    carry_in = (op_q == OP_CMP) ? 1'b1 : p_q[0];
    sum      = {1'b0, a_q} + {1'b0, b_opnd} + {{WIDTH{1'b0}}, carry_in};
    v_bin    = (a_q[WIDTH-1] == b_opnd[WIDTH-1]) && (sum[WIDTH-1] != a_q[WIDTH-1]);
    case (op_q)
      OP_ORA:  alu_res = a_q | m_q;
      OP_AND:  alu_res = a_q & m_q;
      OP_EOR:  alu_res = a_q ^ m_q;
      OP_LDA:  alu_res = m_q;
      OP_STA:  alu_res = a_q;
      default: alu_res = sum[WIDTH-1:0];
    endcase
  end

  // Decimal result built nibble by nibble so each digit's carry/borrow
  // ripples into the next digit after correction.
  logic [WIDTH-1:0] dec_res;
  logic             dec_c;
  logic [4:0]       nib_t;
  logic [3:0]       nib_d;

  always_comb begin
    dec_res = '0;
    dec_c   = p_q[0];
    nib_t   = '0;
    nib_d   = '0;
    for (int i = 0; i < WIDTH / 4; i++) begin
      nib_t = {1'b0, a_q[4*i +: 4]} + {1'b0, b_opnd[4*i +: 4]} + {4'b0, dec_c};
      if (op_q == OP_ADC) begin
        dec_c = (nib_t > 5'd9);
        nib_d = dec_c ? (nib_t[3:0] + 4'd6) : nib_t[3:0];
      end else begin
        dec_c = nib_t[4];
        nib_d = dec_c ? nib_t[3:0] : (nib_t[3:0] - 4'd6);
      end
      dec_res[4*i +: 4] = nib_d;
    end
  end

  logic dec_mode;
  assign dec_mode = (DECIMAL != 0) && p_q[3];

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    p_d      = p_q;
    m_d      = m_q;
    op_d     = op_q;
    ea_d     = ea_q;
    o_data_d = o_data_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          ea_d = ea;
          op_d = opcode[7:5];
          if (opcode[1:0] != 2'b01) begin
            done_d = 1'b1;
            err_d  = 1'b1;
          end else if (opcode[7:5] == OP_STA) begin
            state_d  = S_WR_LO;
            o_data_d = a_q[7:0];
          end else begin
            state_d = S_RD_LO;
          end
        end else if (p_load) begin
          p_d = p_in | 8'h20;
        end
      end
      S_RD_LO, S_RD_HI: begin
        if (ready) begin
          // Shift the byte in from the top: LO then HI leaves {hi, lo}.
          m_d     = WIDTH'({i_data, m_q} >> 8);
          state_d = (state_q == S_RD_LO && WIDTH == 16) ? S_RD_HI : S_EXEC;
        end
      end
      S_EXEC: begin
        state_d = S_IDLE;
        done_d  = 1'b1;
        case (op_q)
          OP_ADC, OP_SBC: begin
            if (dec_mode) begin
              state_d = S_DEC;
              done_d  = 1'b0;
            end else begin
              a_d  = alu_res;
              p_d[7] = alu_res[WIDTH-1];
              p_d[6] = v_bin;
              p_d[1] = (alu_res == '0);
              p_d[0] = sum[WIDTH];
            end
          end
          OP_CMP: begin
            p_d[7] = alu_res[WIDTH-1];
            p_d[1] = (alu_res == '0);
            p_d[0] = sum[WIDTH];
          end
          default: begin
            a_d  = alu_res;
            p_d[7] = alu_res[WIDTH-1];
            p_d[1] = (alu_res == '0);
          end
        endcase
      end
      S_DEC: begin
        // Inputs are untouched since EXEC, so the decimal path is recomputed here.
        a_d    = dec_res;
        p_d[7] = dec_res[WIDTH-1];
        p_d[6] = v_bin;
        p_d[1] = (dec_res == '0);
        p_d[0] = dec_c;
        state_d = S_IDLE;
        done_d  = 1'b1;
      end
      S_WR_LO: begin
        if (ready) begin
          if (WIDTH == 16) begin
            state_d  = S_WR_HI;
            o_data_d = 8'(a_q >> 8);
          end else begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end
        end
      end
      S_WR_HI: begin
        if (ready) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      p_q      <= 8'h24;
      m_q      <= '0;
      op_q     <= '0;
      ea_q     <= '0;
      o_data_q <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      p_q      <= p_d;
      m_q      <= m_d;
      op_q     <= op_d;
      ea_q     <= ea_d;
      o_data_q <= o_data_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  // Bus controls decode straight from state so reset drops them without a clock.
  assign address = (state_q == S_RD_HI || state_q == S_WR_HI) ? ea_q + 16'd1 : ea_q;
  assign read    = (state_q == S_RD_LO) || (state_q == S_RD_HI);
  assign wren    = (state_q == S_WR_LO) || (state_q == S_WR_HI);
  assign o_data  = o_data_q;
  assign a_out   = a_q;
  assign p_out   = p_q;
  assign busy    = (state_q != S_IDLE);
  assign done    = done_q;
  assign err     = err_q;

endmodule

// File: tb/tb_cpu_grp1_exec.sv
// tb/tb_cpu_grp1_exec.sv - directed self-checking bench for cpu_grp1_exec
module tb_cpu_grp1_exec;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  logic        start8, start16, p_load8, p_load16, ready;
  logic [7:0]  opcode, p_in;
  logic [15:0] ea;
  logic [15:0] addr8, addr16;
  logic [7:0]  odata8, odata16, idata8, idata16;
  logic        rd8, rd16, wr8, wr16;
  logic [7:0]  a8;
  logic [15:0] a16;
  logic [7:0]  p8, p16;
  logic        busy8, busy16, done8, done16, err8, err16;

  logic [7:0] mem [0:65535];
  assign idata8  = mem[addr8];
  assign idata16 = mem[addr16];

  cpu_grp1_exec #(.WIDTH(8), .DECIMAL(1)) u8 (
    .clock(clock), .reset_n(reset_n), .start(start8), .opcode(opcode), .ea(ea),
    .p_load(p_load8), .p_in(p_in), .address(addr8), .i_data(idata8), .o_data(odata8),
    .read(rd8), .wren(wr8), .ready(ready), .a_out(a8), .p_out(p8),
    .busy(busy8), .done(done8), .err(err8)
  );

  cpu_grp1_exec #(.WIDTH(16), .DECIMAL(1)) u16 (
    .clock(clock), .reset_n(reset_n), .start(start16), .opcode(opcode), .ea(ea),
    .p_load(p_load16), .p_in(p_in), .address(addr16), .i_data(idata16), .o_data(odata16),
    .read(rd16), .wren(wr16), .ready(ready), .a_out(a16), .p_out(p16),
    .busy(busy16), .done(done16), .err(err16)
  );

  int checks = 0;
  int passed = 0;

  int          lat, rd_cycles, wr_cycles;
  bit          saw_err;
  logic [15:0] first_rd_addr;
  logic [15:0] wa_q[$];
  logic [7:0]  wd_q[$];

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  // Starts one instruction and follows it to done; returns in the done cycle
  // so the next issue is back-to-back. lat = -1 when the budget runs out.
  task automatic issue(input bit w16, input logic [7:0] op, input logic [15:0] addr, input int limit);
    bit fin;
    opcode = op;
    ea     = addr;
    if (w16) start16 = 1'b1; else start8 = 1'b1;
    tick;
    start8 = 1'b0; start16 = 1'b0; p_load8 = 1'b0;
    lat = 1; rd_cycles = 0; wr_cycles = 0; saw_err = 1'b0; first_rd_addr = 16'hxxxx;
    wa_q.delete(); wd_q.delete();
    fin = 1'b0;
    while (!fin) begin
      if (w16 ? rd16 : rd8) begin
        if (rd_cycles == 0) first_rd_addr = w16 ? addr16 : addr8;
        rd_cycles++;
      end
      if (w16 ? wr16 : wr8) begin
        wr_cycles++;
        if (ready) begin
          wa_q.push_back(w16 ? addr16 : addr8);
          wd_q.push_back(w16 ? odata16 : odata8);
        end
      end
      if (w16 ? done16 : done8) begin
        saw_err = w16 ? err16 : err8;
        fin = 1'b1;
      end else if (lat >= limit) begin
        lat = -1;
        fin = 1'b1;
      end else begin
        tick;
        lat++;
      end
    end
  endtask

  task automatic test_reset;
    checks++;
    if ({a8, p8, addr8, odata8, rd8, wr8, busy8, done8, err8} !== {8'h00, 8'h24, 16'h0000, 8'h00, 5'b0})
      $display("FAIL reset8: got a=%h p=%h addr=%h od=%h ctl=%b", a8, p8, addr8, odata8, {rd8, wr8, busy8, done8, err8});
    else passed++;
    checks++;
    if ({a16, p16, addr16, odata16, rd16, wr16, busy16, done16, err16} !== {16'h0000, 8'h24, 16'h0000, 8'h00, 5'b0})
      $display("FAIL reset16: got a=%h p=%h addr=%h od=%h ctl=%b", a16, p16, addr16, odata16, {rd16, wr16, busy16, done16, err16});
    else passed++;
  endtask

  task automatic test_adc_bin;
    p_in = 8'h20; p_load8 = 1'b1; tick; p_load8 = 1'b0;
    checks++;
    if (p8 !== 8'h20) $display("FAIL pload20: got %h expected 20", p8); else passed++;
    mem[16'h1234] = 8'h50;
    issue(1'b0, 8'hAD, 16'h1234, 20);
    checks++;
    if (lat !== 3 || a8 !== 8'h50) $display("FAIL lda50: got lat=%0d a=%h expected lat=3 a=50", lat, a8); else passed++;
    issue(1'b0, 8'h6D, 16'h1234, 20);
    checks++;
    if (first_rd_addr !== 16'h1234) $display("FAIL adc_addr: got %h expected 1234", first_rd_addr); else passed++;
    checks++;
    if (lat !== 3) $display("FAIL adc_lat: got %0d expected 3", lat); else passed++;
    checks++;
    if (a8 !== 8'hA0 || p8 !== 8'hE0) $display("FAIL adc_bin: got a=%h p=%h expected a=a0 p=e0", a8, p8); else passed++;
  endtask

  task automatic test_adc_dec;
    p_in = 8'h28; p_load8 = 1'b1; tick; p_load8 = 1'b0;
    mem[16'h0200] = 8'h19; mem[16'h0201] = 8'h28;
    mem[16'h0202] = 8'h99; mem[16'h0203] = 8'h01;
    mem[16'h0204] = 8'h42; mem[16'h0205] = 8'h15;
    issue(1'b0, 8'hAD, 16'h0200, 20);
    issue(1'b0, 8'h6D, 16'h0201, 20);
    checks++;
    if (lat !== 4 || a8 !== 8'h47 || p8 !== 8'h28)
      $display("FAIL dec_19_28: got lat=%0d a=%h p=%h expected lat=4 a=47 p=28", lat, a8, p8);
    else passed++;
    issue(1'b0, 8'hAD, 16'h0202, 20);
    issue(1'b0, 8'h6D, 16'h0203, 20);
    checks++;
    if (a8 !== 8'h00 || p8 !== 8'h2B)
      $display("FAIL dec_99_01: got a=%h p=%h expected a=00 p=2b", a8, p8);
    else passed++;
    issue(1'b0, 8'hAD, 16'h0204, 20);
    issue(1'b0, 8'hED, 16'h0205, 20);
    checks++;
    if (lat !== 4 || a8 !== 8'h27 || p8 !== 8'h29)
      $display("FAIL dec_sbc: got lat=%0d a=%h p=%h expected lat=4 a=27 p=29", lat, a8, p8);
    else passed++;
  endtask

  task automatic test_sta16;
    mem[16'h3000] = 8'hEF; mem[16'h3001] = 8'hBE;
    issue(1'b1, 8'hAD, 16'h3000, 20);
    checks++;
    if (lat !== 4 || a16 !== 16'hBEEF || p16 !== 8'hA4)
      $display("FAIL lda16: got lat=%0d a=%h p=%h expected lat=4 a=beef p=a4", lat, a16, p16);
    else passed++;
    issue(1'b1, 8'h8D, 16'hFFFF, 20);
    checks++;
    if (lat !== 3 || wr_cycles !== 2 || rd_cycles !== 0)
      $display("FAIL sta16_timing: got lat=%0d wren_cycles=%0d rd=%0d expected 3/2/0", lat, wr_cycles, rd_cycles);
    else passed++;
    checks++;
    if (wa_q.size() !== 2 || {wa_q[0], wd_q[0], wa_q[1], wd_q[1]} !== 48'hFFFF_EF_0000_BE)
      $display("FAIL sta16_data: got n=%0d %h:%h %h:%h expected ffff:ef 0000:be",
               wa_q.size(), wa_q[0], wd_q[0], wa_q[1], wd_q[1]);
    else passed++;
    checks++;
    if (p16 !== 8'hA4 || a16 !== 16'hBEEF) $display("FAIL sta16_ap: got a=%h p=%h expected beef/a4", a16, p16); else passed++;
  endtask

  task automatic test_cmp_wait16;
    bit stable;
    bit fin;
    mem[16'h4000] = 8'h00; mem[16'h4001] = 8'h10;
    mem[16'h5000] = 8'h00; mem[16'h5001] = 8'h10;
    issue(1'b1, 8'hAD, 16'h4000, 20);
    opcode = 8'hCD; ea = 16'h5000; ready = 1'b0; start16 = 1'b1;
    tick;
    start16 = 1'b0;
    lat = 1; stable = 1'b1;
    for (int k = 0; k < 3; k++) begin
      if (addr16 !== 16'h5000 || rd16 !== 1'b1 || done16 !== 1'b0) stable = 1'b0;
      ea = 16'h6666;
      tick;
      lat++;
    end
    ready = 1'b1;
    checks++;
    if (stable !== 1'b1) $display("FAIL cmp_wait_stable: got addr=%h read=%b expected 5000/1", addr16, rd16); else passed++;
    fin = 1'b0;
    while (!fin) begin
      if (done16) fin = 1'b1;
      else if (lat >= 20) begin lat = -1; fin = 1'b1; end
      else begin tick; lat++; end
    end
    checks++;
    if (lat !== 7) $display("FAIL cmp_wait_lat: got %0d expected 7", lat); else passed++;
    checks++;
    if (a16 !== 16'h1000 || p16 !== 8'h27) $display("FAIL cmp_flags: got a=%h p=%h expected 1000/27", a16, p16); else passed++;
  endtask

  task automatic test_illegal;
    issue(1'b0, 8'hAA, 16'h1234, 10);
    checks++;
    if (lat !== 1 || saw_err !== 1'b1 || rd_cycles !== 0 || wr_cycles !== 0)
      $display("FAIL illegal: got lat=%0d err=%b rd=%0d wr=%0d expected 1/1/0/0", lat, saw_err, rd_cycles, wr_cycles);
    else passed++;
    checks++;
    if (a8 !== 8'h27 || p8 !== 8'h29) $display("FAIL illegal_ap: got a=%h p=%h expected 27/29", a8, p8); else passed++;
    tick;
    checks++;
    if ({done8, err8} !== 2'b00) $display("FAIL illegal_pulse: got done/err=%b expected 00", {done8, err8}); else passed++;
  endtask

  task automatic test_reset_abort;
    opcode = 8'h8D; ea = 16'h0300; ready = 1'b0; start8 = 1'b1;
    tick;
    start8 = 1'b0;
    checks++;
    if (wr8 !== 1'b1 || addr8 !== 16'h0300 || odata8 !== 8'h27)
      $display("FAIL sta_wr_lo: got wren=%b addr=%h od=%h expected 1/0300/27", wr8, addr8, odata8);
    else passed++;
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if ({wr8, rd8, busy8, a8, p8} !== {3'b000, 8'h00, 8'h24})
      $display("FAIL reset_abort: got wren=%b busy=%b a=%h p=%h expected 0/0/00/24", wr8, busy8, a8, p8);
    else passed++;
    tick;
    reset_n = 1'b1;
    ready = 1'b1;
    tick;
  endtask

  task automatic test_lda_pload;
    mem[16'h0400] = 8'h00; mem[16'h0401] = 8'h05;
    issue(1'b0, 8'hAD, 16'h0400, 20);
    checks++;
    if (lat !== 3 || a8 !== 8'h00 || p8 !== 8'h26)
      $display("FAIL lda_zero: got lat=%0d a=%h p=%h expected 3/00/26", lat, a8, p8);
    else passed++;
    tick;
    p_in = 8'h09; p_load8 = 1'b1; tick; p_load8 = 1'b0;
    checks++;
    if (p8 !== 8'h29) $display("FAIL pload09: got %h expected 29", p8); else passed++;
    p_in = 8'hC3; p_load8 = 1'b1;
    issue(1'b0, 8'hAD, 16'h0401, 20);
    checks++;
    if (a8 !== 8'h05 || p8 !== 8'h29) $display("FAIL pload_start: got a=%h p=%h expected 05/29", a8, p8); else passed++;
  endtask

  task automatic test_back_to_back;
    mem[16'h0402] = 8'hF0; mem[16'h0403] = 8'hFF; mem[16'h0404] = 8'h0C;
    issue(1'b0, 8'h0D, 16'h0402, 20);
    checks++;
    if (lat !== 3 || a8 !== 8'hF5 || p8 !== 8'hA9) $display("FAIL b2b_ora: got lat=%0d a=%h p=%h expected 3/f5/a9", lat, a8, p8); else passed++;
    issue(1'b0, 8'h4D, 16'h0403, 20);
    checks++;
    if (lat !== 3 || a8 !== 8'h0A || p8 !== 8'h29) $display("FAIL b2b_eor: got lat=%0d a=%h p=%h expected 3/0a/29", lat, a8, p8); else passed++;
    issue(1'b0, 8'h2D, 16'h0404, 20);
    checks++;
    if (lat !== 3 || a8 !== 8'h08 || p8 !== 8'h29) $display("FAIL b2b_and: got lat=%0d a=%h p=%h expected 3/08/29", lat, a8, p8); else passed++;
  endtask

  initial begin
    start8 = 1'b0; start16 = 1'b0; p_load8 = 1'b0; p_load16 = 1'b0;
    ready = 1'b1; opcode = 8'h00; ea = 16'h0000; p_in = 8'h00;
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    tick; tick;
    test_reset;
    reset_n = 1'b1;
    tick;
    test_adc_bin;
    test_adc_dec;
    test_sta16;
    test_cmp_wait16;
    test_illegal;
    test_reset_abort;
    test_lda_pload;
    test_back_to_back;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
